// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } if_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Instruction-memory request/response bundle for the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/if_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_reg
// Description : Next-fetch program counter: word-aligned branch load, +4 step.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load,
    input  wire logic [31:0] target,
    input  wire logic        inc,
    output logic      [31:0] pc_q
);

    localparam logic [31:0] c_word_mask = ~32'h0000_0003;

    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= target & c_word_mask;
        end else if (inc) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign pc_q = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage; presents {PC+4, instruction} to IF/ID.
//               Optional macro IF_ALIGN_CHECK_EN adds a sticky align_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         freeze,
    input  wire logic         branch_taken,
    input  wire logic [31:0]  branch_addr,
    if_stage_if.master        imem,
    output logic              fetch_valid,
    output logic      [31:0]  pc,
    output logic      [31:0]  instruction
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    if_state_e   r_state;
    if_state_e   w_state_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic [31:0] r_inst_buf;
    logic [31:0] w_inst_nxt;
    logic        w_pc_inc;
    logic        w_req;
    logic [31:0] w_pc_reg;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (branch_taken),
        .target (branch_addr),
        .inc    (w_pc_inc),
        .pc_q   (w_pc_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ISSUE;
            r_kill     <= 1'b0;
            r_inst_buf <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_kill     <= w_kill_nxt;
            r_inst_buf <= w_inst_nxt;
        end
    end

    // A branch always reloads the PC; the FSM only decides what happens to
    // the fetch that may be in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_inst_nxt  = r_inst_buf;
        w_pc_inc    = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            ISSUE: begin
                w_req = !branch_taken;
                if (!branch_taken) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (r_kill || branch_taken) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_inst_nxt  = imem.imem_rdata;
                        w_pc_inc    = 1'b1;
                        w_state_nxt = VALID;
                    end
                end else if (branch_taken) begin
                    w_kill_nxt = 1'b1;
                end
            end
            VALID: begin
                if (branch_taken) begin
                    w_state_nxt = ISSUE;
                end else if (!freeze) begin
                    w_req       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt = ISSUE;
            end
        endcase
    end

    assign imem.imem_req  = w_req && !rst;
    assign imem.imem_addr = w_pc_reg;

    assign fetch_valid = (r_state == VALID);
    assign pc          = fetch_valid ? w_pc_reg   : 32'h0;
    assign instruction = fetch_valid ? r_inst_buf : NOP_INSTR;

`ifdef IF_ALIGN_CHECK_EN
    logic r_align_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else if (branch_taken && (branch_addr[1:0] != 2'b00)) begin
            r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;
`endif

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage ARM pipeline. Holds the program counter, fetches one instruction per request from a variable-latency instruction memory over a req/rvalid handshake, and presents {PC+4, instruction} to the IF/ID pipeline register. Redirects on taken branches from EXE, discarding any in-flight fetch, and holds its output while the hazard unit asserts freeze.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  hazard-unit stall; holds a presented instruction.
- branch_taken  in  1  one-cycle redirect strobe from EXE.
- branch_addr  in  32  redirect target.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  32  fetch address, valid when imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
- imem_rvalid  in  1  response strobe; exactly one per request, in order, never in the request cycle.
- fetch_valid  out  1  pc/instruction carry a real fetch.
- pc  out  32  fetch address + 4 (0 when fetch_valid=0).
- instruction  out  32  fetched word (32'h0 when fetch_valid=0).
- align_err  out  1  only with IF_ALIGN_CHECK_EN; see Configuration.

## Operation
- Registers: state, pc_reg (next fetch address), inst_buf, kill (in-flight response is stale).
- States: ISSUE, WAIT, VALID.
- ISSUE: imem_req = !branch_taken, imem_addr = pc_reg. Branch → pc_reg <= target, stay ISSUE. Else → WAIT.
- WAIT: no request. On imem_rvalid:
  - kill=1 or branch_taken → discard, clear kill, → ISSUE.
  - else inst_buf <= imem_rdata, pc_reg <= pc_reg + 4, → VALID.
  - Branch without rvalid → pc_reg <= target, kill <= 1, stay WAIT.
- VALID: fetch_valid=1, instruction=inst_buf, pc=pc_reg.
  - branch_taken (priority over freeze) → pc_reg <= target, → ISSUE, no request.
  - freeze → hold all.
  - else instruction consumed; imem_req=1 at pc_reg in the same cycle, → WAIT.
- Branch target: pc_reg <= {branch_addr[31:2], 2'b00}.
- pc_reg + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 0), no flag.
- Repeated branches while kill=1 update pc_reg; kill stays 1 until one response is discarded.
- freeze is ignored in ISSUE and WAIT.
- imem_rvalid in ISSUE or VALID is a protocol violation; ignored.

## Timing
- Reset values: state=ISSUE, pc_reg=RESET_PC, kill=0, inst_buf=0, fetch_valid=0, pc=0, instruction=0, imem_req=0 during the reset cycle, align_err=0.
- First request in the first cycle after rst deasserts.
- imem_req/imem_addr/outputs are combinational from state and inputs; all state updates on the clk edge.
- 1-cycle memory: request at T, rvalid at T+1, fetch_valid at T+2. Steady throughput one instruction per 2 cycles.
- Branch redirect: first request to the target in the cycle after branch_taken (ISSUE/VALID), or the cycle after the stale response (WAIT).
- Instruction memory shares rst; no responses are outstanding across reset.

## Configuration
- IF_ALIGN_CHECK_EN defined: align_err port exists; set sticky when branch_taken=1 with branch_addr[1:0]≠0 and the branch is accepted; cleared only by rst. Target is still masked to word alignment.
- Not defined: align_err port absent; low address bits are silently masked.

## Structure
- Package if_pkg: state enum (ISSUE, WAIT, VALID), PC_STEP=32'd4, NOP_INSTR=32'h0, default RESET_PC.
- Sub-module if_pc_reg: pc_reg with sync reset, branch load with masking, +4 increment, hold. FSM, kill, and inst_buf stay in if_stage.

## Test plan
- Reset, 1-cycle memory, RESET_PC=0, imem word = address: requests at 0,4,8 on alternate cycles; fetch_valid outputs pc=4/inst=0, pc=8/inst=4, pc=12/inst=8.
- freeze held 3 cycles in VALID with pc=8: outputs stay pc=8/inst=4, no imem_req; request for 8 issues on release.
- Branch to 32'h100 in WAIT, 3-cycle memory: stale response discarded, fetch_valid stays 0, next request at 32'h100, presented pc=32'h104.
- branch_taken together with freeze in VALID: freeze overridden, next request at the target, old instruction never reappears.
- Branch to 32'h0000_0203: fetch at 32'h200; with IF_ALIGN_CHECK_EN align_err=1 until rst.
- Branch to 32'hFFFF_FFFC: pc output 32'h0, next request at 32'h0.
